// File: rtl/serial_sub_seq_if.sv
// rtl/serial_sub_seq_if.sv - start/result handshake bundle for the bit-serial subtractor
//
// Purpose: groups the request and result signals exchanged between a requesting
// datapath (master) and serial_sub_seq (slave).
// Signals:
//   start  request, sampled only while ready=1
//   a, b   WIDTH-bit minuend / subtrahend
//   bin    borrow-in to bit 0
//   ready  sequencer can accept a start (IDLE or DONE)
//   busy   serial subtraction in progress
//   done   one-cycle pulse, diff/bout valid
//   diff   WIDTH-bit difference
//   bout   borrow out of the top bit
interface serial_sub_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_seq.sv
// rtl/serial_sub_seq.sv - bit-serial multi-word subtractor sequencer
//
// Purpose: captures a WIDTH-bit minuend, subtrahend and borrow-in on an accepted
// start, then evaluates one full-subtractor cell per clock, LSB first, threading
// the borrow between cycles. After WIDTH cycles the difference and final borrow
// are registered and flagged with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_sub_seq_if slave modport (start/a/b/bin in; ready/busy/done/diff/bout out)
module serial_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_sub_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt;
  logic [WIDTH-1:0] b_sh, b_sh_nxt;
  logic [WIDTH-1:0] d_sh, d_sh_nxt;
  logic             br, br_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] diff_q, diff_nxt;
  logic             bout_q, bout_nxt;

  logic             cell_d;
  logic             cell_br;
  logic [WIDTH-1:0] d_shifted;
  logic             last_bit;

  // The shared one-bit full-subtractor cell.
  assign cell_d  = a_sh[0] ^ b_sh[0] ^ br;
  assign cell_br = (~a_sh[0] & br) | (~a_sh[0] & b_sh[0]) | (b_sh[0] & br);

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_d_one
      assign d_shifted = cell_d;
    end else begin : g_d_wide
      assign d_shifted = {cell_d, d_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_sh   <= a_sh_nxt;
      b_sh   <= b_sh_nxt;
      d_sh   <= d_sh_nxt;
      br     <= br_nxt;
      cnt    <= cnt_nxt;
      diff_q <= diff_nxt;
      bout_q <= bout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    d_sh_nxt  = d_sh;
    br_nxt    = br;
    cnt_nxt   = cnt;
    diff_nxt  = diff_q;
    bout_nxt  = bout_q;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_nxt  = bus.a;
          b_sh_nxt  = bus.b;
          br_nxt    = bus.bin;
          d_sh_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        a_sh_nxt = a_sh >> 1;
        b_sh_nxt = b_sh >> 1;
        d_sh_nxt = d_shifted;
        br_nxt   = cell_br;
        cnt_nxt  = cnt + CW'(1);
        if (last_bit) begin
          // Results are captured from the final cell evaluation directly, so they
          // are valid in the same cycle that done rises.
          diff_nxt  = d_shifted;
          bout_nxt  = cell_br;
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.ready = (state != S_RUN);
  assign bus.busy  = (state == S_RUN);
  assign bus.done  = (state == S_DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_sub_seq.sv
// tb/tb_serial_sub_seq.sv - self-checking bench for serial_sub_seq (WIDTH=8 and WIDTH=1)
module tb_serial_sub_seq;

  logic clk;
  logic rst_n;

  serial_sub_seq_if #(.WIDTH(8)) i8 ();
  serial_sub_seq_if #(.WIDTH(1)) i1 ();

  serial_sub_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_sub_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic bin;
    logic d;
    logic bo;
  } vec1_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo);
    int r;
    r  = int'(a) - int'(b) - int'(bin);
    d  = r[7:0];
    bo = (r < 0);
  endtask

  // One WIDTH=8 operation with full latency checking: busy for exactly 8 cycles
  // after the accepting edge, done on the 9th, then back to idle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] exp_d, input logic exp_bo, input string tag);
    int busy_n;
    @(negedge clk);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.bin = bin;
    @(posedge clk);
    #1 i8.start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i8.busy && !i8.done && !i8.ready) busy_n++;
    end
    check({tag, " busy_cycles"}, busy_n, 8);
    @(negedge clk);
    check({tag, " done"}, {31'd0, i8.done}, 1);
    check({tag, " diff"}, {24'd0, i8.diff}, {24'd0, exp_d});
    check({tag, " bout"}, {31'd0, i8.bout}, {31'd0, exp_bo});
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, i8.done}, 0);
  endtask

  task automatic op1(input logic a, input logic b, input logic bin,
                     input logic exp_d, input logic exp_bo, input string tag);
    @(negedge clk);
    i1.start = 1'b1; i1.a = a; i1.b = b; i1.bin = bin;
    @(posedge clk);
    #1 i1.start = 1'b0;
    @(negedge clk);
    check({tag, " busy"}, {30'd0, i1.busy, i1.done}, 32'b10);
    @(negedge clk);
    check({tag, " done"}, {31'd0, i1.done}, 1);
    check({tag, " d"}, {31'd0, i1.diff}, {31'd0, exp_d});
    check({tag, " br"}, {31'd0, i1.bout}, {31'd0, exp_bo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec8_t v8 [4];
    vec1_t v1 [8];
    logic [7:0] ed;
    logic       eb;
    logic [7:0] ra, rb;
    logic       rbin;
    int pulses, last_pulse, viol, unstable, late_done;

    v8[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0};
    v8[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1};
    v8[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1};
    v8[3] = '{a: 8'h80, b: 8'h7F, bin: 1'b1, d: 8'h00, bo: 1'b0};

    v1[0] = '{a: 0, b: 0, bin: 0, d: 0, bo: 0};
    v1[1] = '{a: 0, b: 0, bin: 1, d: 1, bo: 1};
    v1[2] = '{a: 0, b: 1, bin: 0, d: 1, bo: 1};
    v1[3] = '{a: 0, b: 1, bin: 1, d: 0, bo: 1};
    v1[4] = '{a: 1, b: 0, bin: 0, d: 1, bo: 0};
    v1[5] = '{a: 1, b: 0, bin: 1, d: 0, bo: 0};
    v1[6] = '{a: 1, b: 1, bin: 0, d: 0, bo: 0};
    v1[7] = '{a: 1, b: 1, bin: 1, d: 1, bo: 1};

    i8.start = 0; i8.a = '0; i8.b = '0; i8.bin = 0;
    i1.start = 0; i1.a = '0; i1.b = '0; i1.bin = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, i8.ready}, 1);
    check("reset busy", {31'd0, i8.busy}, 0);
    check("reset done", {31'd0, i8.done}, 0);
    check("reset diff", {24'd0, i8.diff}, 0);
    check("reset bout", {31'd0, i8.bout}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      op8(v8[i].a, v8[i].b, v8[i].bin, v8[i].d, v8[i].bo, $sformatf("vec%0d", i));

    // Back-to-back with start held high.
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF; i8.bin = 1'b0;
    pulses = 0; last_pulse = -1; viol = 0; unstable = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i8.ready !== ~i8.busy) viol++;
      if (i8.done && i8.busy) viol++;
      if (i8.done) begin
        if (last_pulse >= 0) check($sformatf("b2b spacing@%0d", i), i - last_pulse, 9);
        check($sformatf("b2b diff@%0d", i), {24'd0, i8.diff}, 0);
        check($sformatf("b2b bout@%0d", i), {31'd0, i8.bout}, 0);
        last_pulse = i;
        pulses++;
      end else if (pulses > 0) begin
        if (i8.diff !== 8'h00 || i8.bout !== 1'b0) unstable++;
      end
    end
    i8.start = 1'b0;
    check("b2b pulse count", pulses, 3);
    check("b2b ready/busy/done rules", viol, 0);
    check("b2b result stable", unstable, 0);
    repeat (12) @(negedge clk);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      model8(ra, rb, rbin, ed, eb);
      op8(ra, rb, rbin, ed, eb, $sformatf("rnd%0d %0h-%0h-%0d", n, ra, rb, rbin));
    end

    // Exhaustive single-bit cell at WIDTH=1.
    for (int i = 0; i < 8; i++)
      op1(v1[i].a, v1[i].b, v1[i].bin, v1[i].d, v1[i].bo, $sformatf("w1 %0d%0d%0d", v1[i].a, v1[i].b, v1[i].bin));

    // start during RUN is ignored.
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h80; i8.b = 8'h01; i8.bin = 1'b0;
    @(posedge clk);
    #1 i8.start = 1'b0;
    repeat (3) @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h11; i8.b = 8'h11;
    @(negedge clk);
    i8.start = 1'b0; i8.a = 8'h00; i8.b = 8'h00;
    repeat (4) @(negedge clk);
    check("ign still busy", {30'd0, i8.busy, i8.done}, 32'b10);
    @(negedge clk);
    check("ign done", {31'd0, i8.done}, 1);
    check("ign diff", {24'd0, i8.diff}, 32'h7F);
    check("ign bout", {31'd0, i8.bout}, 0);
    @(negedge clk);
    check("ign not queued", {31'd0, i8.busy}, 0);
    @(negedge clk);
    check("ign idle", {31'd0, i8.ready}, 1);

    // Asynchronous reset mid-RUN at cnt=4.
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h33; i8.b = 8'h11; i8.bin = 1'b0;
    @(posedge clk);
    #1 i8.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid busy before reset", {31'd0, i8.busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", {31'd0, i8.busy}, 0);
    check("mid reset ready", {31'd0, i8.ready}, 1);
    check("mid reset done", {31'd0, i8.done}, 0);
    check("mid reset diff", {24'd0, i8.diff}, 0);
    check("mid reset bout", {31'd0, i8.bout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i8.done || i8.busy) late_done++;
    end
    check("no done after reset", late_done, 0);
    op8(8'h0A, 8'h04, 1'b0, 8'h06, 1'b0, "post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_seq.md
# serial_sub_seq

Bit-serial multi-word subtractor sequencer. It accepts a WIDTH-bit minuend, subtrahend and borrow-in on a start handshake. It then drives a single one-bit full-subtractor cell once per clock, LSB first, threading the borrow between cycles, and returns the WIDTH-bit difference and final borrow with a done pulse. It sits between a requesting datapath and the shared one-bit subtractor cell, so that wide subtractions can reuse one cell.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in to bit 0; captured on accepted start.
- ready  output  1  high in IDLE and DONE, when a new start is accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference, a - b - bin mod 2^WIDTH.
- bout  output  1  final borrow out of bit WIDTH-1.

## Operation
- Per-bit cell function: d = ai ^ bi ^ br; br_next = (~ai & br) | (~ai & bi) | (bi & br).
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- Internal registers:
  - a_sh and b_sh: WIDTH-bit shift registers.
  - d_sh: WIDTH-bit result shift register.
  - br: 1-bit borrow register.
  - cnt: bit counter, width clog2(WIDTH+1).
- IDLE, start=1:
  - load a_sh=a, b_sh=b, br=bin, cnt=0; clear d_sh.
  - go to RUN.
- RUN, each cycle:
  - compute d and br_next from a_sh[0], b_sh[0] and br.
  - shift a_sh and b_sh right by one.
  - shift d into d_sh from the MSB end (d_sh = {d, d_sh[WIDTH-1:1]}).
  - br = br_next; cnt = cnt + 1.
  - when cnt reaches WIDTH-1 this cycle, go to DONE.
- DONE:
  - copy d_sh to diff and br to bout; both are registered at entry to DONE.
  - start=1: accept the new operands exactly as from IDLE and go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- diff and bout hold their last value until the next entry to DONE. They do not change during RUN.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout=1 iff a < b + bin, with unsigned comparison at WIDTH+1 bits.

## Timing
- Reset (rst_n=0, asynchronous, any state including mid-RUN):
  - state=IDLE; ready=1, busy=0, done=0.
  - diff=0, bout=0.
  - all internal registers cleared.
  - any operation in progress is abandoned with no done pulse.
- Release of rst_n takes effect on the next rising clk edge; start is sampled from that edge on.
- Latency: start accepted at edge k.
  - busy=1 for cycles following edges k .. k+WIDTH-1 (WIDTH cycles).
  - done=1 for exactly one cycle following edge k+WIDTH, with diff and bout valid from that same cycle.
- Throughput: one operation per WIDTH+1 cycles with start held high continuously.
- WIDTH=1: RUN lasts one cycle; done follows at edge k+1.
- done and busy are never high simultaneously. ready is the complement of busy.

## Test plan
- Reset, then WIDTH=8, a=8'h05, b=8'h03, bin=0, start pulse -> busy for 8 cycles, then done=1 one cycle with diff=8'h02, bout=0.
- a=8'h03, b=8'h05, bin=0 -> diff=8'hFE, bout=1. Then a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1 (full borrow ripple).
- a=8'hFF, b=8'hFF, bin=0 and start held high for 30 cycles -> done pulses exactly 9 cycles apart, each with diff=8'h00, bout=0; results stable between pulses.
- During RUN of 8'h80 - 8'h01, pulse start with a=8'h11, b=8'h11 -> ignored; done shows diff=8'h7F, bout=0. Then exhaustive check of all 8 single-bit (a,b,bin) cases at WIDTH=1 against d and br_next.
- Assert rst_n=0 mid-RUN, at cnt=4 -> immediately busy=0, ready=1, done=0, diff=0, bout=0. No done pulse follows. A subsequent 8'h0A - 8'h04 gives diff=8'h06, bout=0.
